// File: rtl/maxpool_2x2_stream.sv
// Streaming 2x2 max-pool: horizontal max in one register stage, vertical max via a row buffer.
// Optional output ReLU clamp selected by the MAXPOOL_RELU_EN macro.
module maxpool_2x2_stream #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned SYSTOLIC_SIZE = 16,
  parameter int unsigned NUM_MODULES   = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      clear,
  input  logic                                      in_valid,
  input  logic [NUM_MODULES*DATA_WIDTH*2-1:0]       data_in,
  output logic                                      out_valid,
  output logic [(NUM_MODULES/2)*DATA_WIDTH*2-1:0]   data_out,
  output logic                                      tile_done
);

  localparam int unsigned LW        = 2 * DATA_WIDTH;
  localparam int unsigned OUT_LANES = NUM_MODULES / 2;
  localparam int unsigned OUT_W     = OUT_LANES * LW;
  localparam int unsigned PAIRS     = SYSTOLIC_SIZE / 2;
  localparam int unsigned CNT_W     = (PAIRS > 1) ? $clog2(PAIRS) : 1;

  logic [OUT_W-1:0] h_row_q, h_row_d;
  logic             h_valid_q, h_valid_d;
  logic [OUT_W-1:0] row_buf_q, row_buf_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] pair_cnt_q, pair_cnt_d;
  logic             out_valid_q, out_valid_d;
  logic             tile_done_q, tile_done_d;
  logic [OUT_W-1:0] data_out_q, data_out_d;

  logic signed [LW-1:0] h_a, h_b;
  logic signed [LW-1:0] v_a, v_b, v_max;

  // Stage H: pairwise max of adjacent columns; a row in a clear cycle is dropped.
  always_comb begin
    h_row_d   = h_row_q;
    h_valid_d = 1'b0;
    h_a       = '0;
    h_b       = '0;
    if (!clear && in_valid) begin
      h_valid_d = 1'b1;
      for (int unsigned j = 0; j < OUT_LANES; j++) begin
        h_a = data_in[(2*j)*LW +: LW];
        h_b = data_in[(2*j+1)*LW +: LW];
        h_row_d[j*LW +: LW] = (h_a > h_b) ? h_a : h_b;
      end
    end
  end

  // Stage V: even rows park in row_buf, odd rows complete the pair.
  always_comb begin
    row_buf_d   = row_buf_q;
    parity_d    = parity_q;
    pair_cnt_d  = pair_cnt_q;
    out_valid_d = 1'b0;
    tile_done_d = 1'b0;
    data_out_d  = data_out_q;
    v_a         = '0;
    v_b         = '0;
    v_max       = '0;
    if (clear) begin
      parity_d   = 1'b0;
      pair_cnt_d = '0;
    end else if (h_valid_q) begin
      if (!parity_q) begin
        row_buf_d = h_row_q;
        parity_d  = 1'b1;
      end else begin
        for (int unsigned j = 0; j < OUT_LANES; j++) begin
          v_a   = row_buf_q[j*LW +: LW];
          v_b   = h_row_q[j*LW +: LW];
          v_max = (v_a > v_b) ? v_a : v_b;
`ifdef MAXPOOL_RELU_EN
          data_out_d[j*LW +: LW] = v_max[LW-1] ? '0 : v_max;
`else
          data_out_d[j*LW +: LW] = v_max;
`endif
        end
        out_valid_d = 1'b1;
        parity_d    = 1'b0;
        if (pair_cnt_q == CNT_W'(PAIRS - 1)) begin
          pair_cnt_d  = '0;
          tile_done_d = 1'b1;
        end else begin
          pair_cnt_d = pair_cnt_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_row_q     <= '0;
      h_valid_q   <= 1'b0;
      row_buf_q   <= '0;
      parity_q    <= 1'b0;
      pair_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      tile_done_q <= 1'b0;
      data_out_q  <= '0;
    end else begin
      h_row_q     <= h_row_d;
      h_valid_q   <= h_valid_d;
      row_buf_q   <= row_buf_d;
      parity_q    <= parity_d;
      pair_cnt_q  <= pair_cnt_d;
      out_valid_q <= out_valid_d;
      tile_done_q <= tile_done_d;
      data_out_q  <= data_out_d;
    end
  end

  assign out_valid = out_valid_q;
  assign tile_done = tile_done_q;
  assign data_out  = data_out_q;

endmodule

// File: tb/tb_maxpool_2x2_stream.sv
// Scoreboard bench for maxpool_2x2_stream: driver pushes expected pooled rows, monitor pops on out_valid.
module tb_maxpool_2x2_stream;

  localparam int unsigned DATA_WIDTH    = 8;
  localparam int unsigned SYSTOLIC_SIZE = 16;
  localparam int unsigned NUM_MODULES   = 16;
  localparam int unsigned LW            = 2 * DATA_WIDTH;
  localparam int unsigned OUT_LANES     = NUM_MODULES / 2;
  localparam int unsigned IN_W          = NUM_MODULES * LW;
  localparam int unsigned OUT_W         = OUT_LANES * LW;
  localparam int          PAIRS         = SYSTOLIC_SIZE / 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             clear;
  logic             in_valid;
  logic [IN_W-1:0]  data_in;
  logic             out_valid;
  logic [OUT_W-1:0] data_out;
  logic             tile_done;

  maxpool_2x2_stream #(
    .DATA_WIDTH(DATA_WIDTH), .SYSTOLIC_SIZE(SYSTOLIC_SIZE), .NUM_MODULES(NUM_MODULES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .data_in(data_in),
    .out_valid(out_valid), .data_out(data_out), .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             td;
    int               cyc;
  } exp_t;

  exp_t             sb_q[$];
  exp_t             mon_e;
  int               cyc = 0;
  int               n_checks = 0;
  int               n_pass = 0;
  logic             have_a;
  logic [IN_W-1:0]  a_row;
  int               pair_m;
  logic [OUT_W-1:0] last_exp;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [OUT_W-1:0] pool(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    logic [OUT_W-1:0] r;
    int m;
    r = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      m = $signed(a[(2*j)*LW +: LW]);
      if ($signed(a[(2*j+1)*LW +: LW]) > m) m = $signed(a[(2*j+1)*LW +: LW]);
      if ($signed(b[(2*j)*LW +: LW]) > m)   m = $signed(b[(2*j)*LW +: LW]);
      if ($signed(b[(2*j+1)*LW +: LW]) > m) m = $signed(b[(2*j+1)*LW +: LW]);
`ifdef MAXPOOL_RELU_EN
      if (m < 0) m = 0;
`endif
      r[j*LW +: LW] = LW'(m);
    end
    return r;
  endfunction

  function automatic logic [IN_W-1:0] mkrow(input int k, input int seed);
    logic [IN_W-1:0] r;
    for (int i = 0; i < NUM_MODULES; i++)
      r[i*LW +: LW] = LW'(((k * 37 + i * 11 + seed * 5) % 97) - 48);
    return r;
  endfunction

  task automatic send_row(input logic [IN_W-1:0] row, input logic use_hand, input logic [OUT_W-1:0] hand);
    exp_t e;
    in_valid = 1'b1;
    data_in  = row;
    clear    = 1'b0;
    if (!have_a) begin
      a_row  = row;
      have_a = 1'b1;
    end else begin
      e.data = use_hand ? hand : pool(a_row, row);
      pair_m++;
      e.td = (pair_m == PAIRS);
      if (e.td) pair_m = 0;
      e.cyc = cyc + 2;
      sb_q.push_back(e);
      last_exp = e.data;
      have_a = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_clear();
    clear    = 1'b1;
    in_valid = 1'b1;
    data_in  = mkrow(99, 99);
    have_a   = 1'b0;
    pair_m   = 0;
    @(posedge clk); #1;
    clear    = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic send_tile(input int seed);
    for (int k = 0; k < SYSTOLIC_SIZE; k++) send_row(mkrow(k, seed), 1'b0, '0);
  endtask

  // Monitor: every out_valid must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n && tile_done && !out_valid) begin
      n_checks++;
      $display("FAIL tile_done_alone actual=1 required=0");
    end
    if (rst_n && out_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_out actual=%h required=no_output", data_out);
      end else begin
        mon_e = sb_q.pop_front();
        chk("data_out", data_out, mon_e.data);
        chk("tile_done", OUT_W'(tile_done), OUT_W'(mon_e.td));
        chk("latency_cycle", OUT_W'(cyc), OUT_W'(mon_e.cyc));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  logic [IN_W-1:0]  ra, rb;
  logic [OUT_W-1:0] hand;
  int               t1_vals [OUT_LANES] = '{16, 14, 12, 10, 10, 12, 14, 16};

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; data_in = '0;
    have_a = 1'b0; pair_m = 0; last_exp = '0;
    idle(2);
    chk("reset_out_valid", OUT_W'(out_valid), '0);
    chk("reset_tile_done", OUT_W'(tile_done), '0);
    chk("reset_data_out", data_out, '0);
    rst_n = 1'b1;
    idle(2);

    // Single pair: ascending then descending lanes.
    for (int i = 0; i < NUM_MODULES; i++) begin
      ra[i*LW +: LW] = LW'(i + 1);
      rb[i*LW +: LW] = LW'(16 - i);
    end
    for (int j = 0; j < OUT_LANES; j++) hand[j*LW +: LW] = LW'(t1_vals[j]);
    send_row(ra, 1'b0, '0);
    send_row(rb, 1'b1, hand);
    idle(3);

    // Signed lanes.
    ra = '0; rb = '0;
    ra[0*LW +: LW] = LW'(-5); ra[1*LW +: LW] = LW'(-3);
    rb[0*LW +: LW] = LW'(-7); rb[1*LW +: LW] = LW'(-4);
    hand = '0;
`ifndef MAXPOOL_RELU_EN
    hand[0 +: LW] = LW'(-3);
`endif
    send_row(ra, 1'b0, '0);
    send_row(rb, 1'b1, hand);
    idle(3);

    // Gapped pair.
    send_row(mkrow(3, 1), 1'b0, '0);
    idle(5);
    send_row(mkrow(8, 2), 1'b0, '0);
    idle(4);

    // Clear with a half-filled pair; data_out must keep the last pooled row.
    send_row(mkrow(5, 7), 1'b0, '0);
    idle(1);
    do_clear();
    idle(1);
    chk("data_out_after_clear", data_out, last_exp);

    // Two back-to-back tiles; tile_done must land on the 8th pair after clear.
    send_tile(3);
    send_tile(4);
    idle(4);

    // Async reset mid-tile with a row pending in the buffer.
    send_row(mkrow(2, 9), 1'b0, '0);
    send_row(mkrow(6, 9), 1'b0, '0);
    send_row(mkrow(1, 9), 1'b0, '0);
    idle(1);
    #2;
    rst_n  = 1'b0;
    have_a = 1'b0;
    pair_m = 0;
    #1;
    chk("async_rst_out_valid", OUT_W'(out_valid), '0);
    chk("async_rst_tile_done", OUT_W'(tile_done), '0);
    chk("async_rst_data_out", data_out, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    send_tile(5);
    idle(5);

    chk("scoreboard_empty", OUT_W'(sb_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
